// File: rtl/tt_ctrl_seq_pkg.sv
// Shared types and default constants for the control-pad sequencer.
package tt_ctrl_seq_pkg;

    // Fixed 3-bit state encoding so the state can be probed and decoded directly.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST_LO = 3'd1,
        RST_HI = 3'd2,
        INC_HI = 3'd3,
        INC_LO = 3'd4,
        ENA    = 3'd5
    } state_e;

    localparam int unsigned DEF_ADDR_W   = 10;
    localparam int unsigned DEF_HALF_CYC = 4;
    localparam int unsigned DEF_CNT_W    = 3;

    // States whose duration is one waveform half-phase.
    function automatic logic is_timed(input state_e s);
        return (s == RST_LO) || (s == RST_HI) || (s == INC_HI) || (s == INC_LO);
    endfunction

endpackage

// File: rtl/tt_ctrl_seq_timer.sv
// Half-phase timer: counts 0..HALF_CYC-1 while run is high, wraps on terminal
// count, holds at zero otherwise. load preloads an arbitrary start value.
module tt_ctrl_seq_timer
    import tt_ctrl_seq_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned HALF_CYC = DEF_HALF_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = run && (cnt_q == LAST);

    // Next count: preload, wrap on terminal count or idle, else increment.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!run || tc) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_ctrl_seq.sv
// Control-pad sequencer: turns a valid/ready address request into the
// select-reset / N x select-increment / enable pad waveform.
// Optional macro TT_CTRL_SEQ_INCR_EN: incremental selection (skip the reset
// pulse when the target is at or above the currently selected address).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only while idle, and req_valid
// may be held high at any time (it is taken in the first ready cycle).
//
// Pad outputs are registered from the current state, so every pad/status
// output trails the state register by one clock.
module tt_ctrl_seq
    import tt_ctrl_seq_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned HALF_CYC = DEF_HALF_CYC,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
    logic              ena_lat_q, ena_lat_d;

    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              cur_valid_q, cur_valid_d;
    logic              sel_rst_n_q, sel_rst_n_d;
    logic              sel_inc_q, sel_inc_d;
    logic              ctrl_ena_q, ctrl_ena_d;

    logic              accept;
    logic              tc;

    // req_ready_q is only ever high while the state register holds IDLE.
    assign accept = req_valid && req_ready_q;

    tt_ctrl_seq_timer #(
        .CNT_W    (CNT_W),
        .HALF_CYC (HALF_CYC)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (is_timed(state_q)),
        .load     (accept),
        .load_val ('0),
        .tc       (tc)
    );

    // Next state, request latch and remaining-increment counter.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        addr_lat_d = addr_lat_q;
        ena_lat_d  = ena_lat_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_lat_d = req_addr;
                    ena_lat_d  = req_ena;
                    rem_d      = req_addr;
                    state_d    = RST_LO;
`ifdef TT_CTRL_SEQ_INCR_EN
                    // Already at or below the target: walk forward from here.
                    if (cur_valid_q && (req_addr >= cur_addr_q)) begin
                        rem_d   = req_addr - cur_addr_q;
                        state_d = (req_addr == cur_addr_q) ? ENA : INC_HI;
                    end
`endif
                end
            end
            RST_LO: begin
                if (tc) state_d = RST_HI;
            end
            RST_HI: begin
                // Without a request in flight this is the post-reset tail.
                if (tc) begin
                    if (!busy_q) begin
                        state_d = IDLE;
                    end else if (rem_q == '0) begin
                        state_d = ENA;
                    end else begin
                        state_d = INC_HI;
                    end
                end
            end
            INC_HI: begin
                if (tc) begin
                    rem_d   = rem_q - ADDR_W'(1);
                    state_d = INC_LO;
                end
            end
            INC_LO: begin
                if (tc) state_d = (rem_q != '0) ? INC_HI : ENA;
            end
            ENA: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered pad and status outputs, derived from the current state.
    always_comb begin
        sel_rst_n_d = (state_q != RST_LO);
        sel_inc_d   = (state_q == INC_HI);
        done_d      = (state_q == ENA);
        req_ready_d = (state_q == IDLE) && !accept;
        ctrl_ena_d  = ctrl_ena_q;
        busy_d      = busy_q;
        cur_addr_d  = cur_addr_q;
        cur_valid_d = cur_valid_q;
        if (accept) begin
            ctrl_ena_d = 1'b0;
            busy_d     = 1'b1;
        end
        if (state_q == ENA) begin
            ctrl_ena_d  = ena_lat_q;
            busy_d      = 1'b0;
            cur_addr_d  = addr_lat_q;
            cur_valid_d = 1'b1;
        end
        // First idle cycle after the reset tail: controller sits at address 0.
        if ((state_q == IDLE) && !cur_valid_q) begin
            cur_addr_d  = '0;
            cur_valid_d = 1'b1;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_LO;
            rem_q       <= '0;
            addr_lat_q  <= '0;
            ena_lat_q   <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cur_addr_q  <= '0;
            cur_valid_q <= 1'b0;
            sel_rst_n_q <= 1'b0;
            sel_inc_q   <= 1'b0;
            ctrl_ena_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            addr_lat_q  <= addr_lat_d;
            ena_lat_q   <= ena_lat_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cur_addr_q  <= cur_addr_d;
            cur_valid_q <= cur_valid_d;
            sel_rst_n_q <= sel_rst_n_d;
            sel_inc_q   <= sel_inc_d;
            ctrl_ena_q  <= ctrl_ena_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign cur_addr       = cur_addr_q;
    assign cur_valid      = cur_valid_q;
    assign ctrl_sel_rst_n = sel_rst_n_q;
    assign ctrl_sel_inc   = sel_inc_q;
    assign ctrl_ena       = ctrl_ena_q;

endmodule

// File: tb/tb_tt_ctrl_seq.sv
// Bench for tt_ctrl_seq: driver issues requests and pushes the expected
// completion (from an address-level model) into a queue; a monitor tracks the
// pad waveform and pops/compares on every done pulse.
module tb_tt_ctrl_seq;

    localparam int ADDR_W   = 10;
    localparam int HALF_CYC = 4;
    localparam int CNT_W    = 3;
    localparam int TMO      = 20000;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ena;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_valid;
    logic              ctrl_sel_rst_n;
    logic              ctrl_sel_inc;
    logic              ctrl_ena;

    tt_ctrl_seq #(
        .ADDR_W   (ADDR_W),
        .HALF_CYC (HALF_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_ena        (req_ena),
        .busy           (busy),
        .done           (done),
        .cur_addr       (cur_addr),
        .cur_valid      (cur_valid),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              ena;
        logic [31:0]       lat;
        logic [31:0]       incs;
        logic [31:0]       rsts;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    logic [ADDR_W-1:0] m_cur_addr;
    logic              m_cur_valid;

    bit mon_en = 0;
    int last_done_cyc = 0;
    int mon_incs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit in_seq, prev_inc, prev_rstn, prev_done;
        int acc_cyc, inc_run, rst_run, rsts;
        exp_t x;
        in_seq = 0; prev_inc = 0; prev_rstn = 1; prev_done = 0;
        acc_cyc = 0; inc_run = 0; rst_run = 0; rsts = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en || !rst_n) begin
                in_seq = 0; prev_inc = 0; prev_rstn = 1; prev_done = 0;
                inc_run = 0; rst_run = 0;
            end else begin
                if (ctrl_sel_inc && !ctrl_sel_rst_n) chk("inc_rst_overlap", 1, 0);
                if ((!ctrl_sel_rst_n || ctrl_sel_inc) && ctrl_ena) chk("ena_during_select", 1, 0);
                if (busy && req_ready) chk("ready_while_busy", 1, 0);
                if (prev_done) chk("done_one_cycle", done, 0);
                if (in_seq) begin
                    if (ctrl_sel_inc) begin
                        if (!prev_inc) mon_incs++;
                        inc_run++;
                    end else if (prev_inc) begin
                        chk("inc_width", inc_run, HALF_CYC);
                        inc_run = 0;
                    end
                    if (!ctrl_sel_rst_n) begin
                        if (prev_rstn) rsts++;
                        rst_run++;
                    end else if (!prev_rstn) begin
                        chk("rst_width", rst_run, HALF_CYC);
                        rst_run = 0;
                    end
                    if (cyc == acc_cyc + 1) begin
                        chk("ena_low_after_accept", ctrl_ena, 0);
                        chk("busy_after_accept", busy, 1);
                    end
                end
                if (done) begin
                    last_done_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        x = exp_q.pop_front();
                        chk("done_latency", cyc - acc_cyc, x.lat);
                        chk("inc_pulses", mon_incs, x.incs);
                        chk("rst_pulses", rsts, x.rsts);
                        chk("cur_addr", cur_addr, x.addr);
                        chk("cur_valid", cur_valid, 1);
                        chk("ctrl_ena", ctrl_ena, x.ena);
                        chk("busy_at_done", busy, 0);
                    end
                    in_seq = 0;
                end
                if (req_valid && req_ready) begin
                    acc_cyc  = cyc;
                    in_seq   = 1;
                    mon_incs = 0;
                    rsts     = 0;
                    inc_run  = 0;
                    rst_run  = 0;
                end
                prev_inc  = ctrl_sel_inc;
                prev_rstn = ctrl_sel_rst_n;
                prev_done = done;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Reset, check reset values, release and check the reset tail waveform.
    task automatic reset_and_check();
        mon_en = 0;
        rst_n  = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_val_sel_rst_n", ctrl_sel_rst_n, 0);
        chk("rst_val_sel_inc", ctrl_sel_inc, 0);
        chk("rst_val_ena", ctrl_ena, 0);
        chk("rst_val_ready", req_ready, 0);
        chk("rst_val_busy", busy, 0);
        chk("rst_val_done", done, 0);
        chk("rst_val_cur_addr", cur_addr, 0);
        chk("rst_val_cur_valid", cur_valid, 0);
        rst_n = 1'b1;
        for (int i = 0; i < HALF_CYC; i++) begin
            @(negedge clk); #1;
            chk("tail_rst_lo", ctrl_sel_rst_n, 0);
            chk("tail_lo_ready", req_ready, 0);
            chk("tail_lo_done", done, 0);
        end
        for (int i = 0; i < HALF_CYC; i++) begin
            @(negedge clk); #1;
            chk("tail_rst_hi", ctrl_sel_rst_n, 1);
            chk("tail_hi_ready", req_ready, 0);
            chk("tail_hi_done", done, 0);
        end
        @(negedge clk); #1;
        chk("tail_ready", req_ready, 1);
        chk("tail_cur_valid", cur_valid, 1);
        chk("tail_cur_addr", cur_addr, 0);
        chk("tail_done", done, 0);
        chk("tail_ena", ctrl_ena, 0);
        m_cur_addr  = '0;
        m_cur_valid = 1'b1;
        mon_en = 1;
    endtask

    // Queue the expected completion and present the request until accepted.
    task automatic send(input logic [ADDR_W-1:0] a, input logic e, input bit b2b);
        exp_t x;
        bit got;
        x.addr = a;
        x.ena  = e;
        x.incs = a;
        x.rsts = 1;
        x.lat  = 2 + 2 * HALF_CYC * (1 + int'(a));
`ifdef TT_CTRL_SEQ_INCR_EN
        if (m_cur_valid && a >= m_cur_addr) begin
            x.incs = a - m_cur_addr;
            x.rsts = 0;
            x.lat  = 2 + 2 * HALF_CYC * int'(a - m_cur_addr);
        end
`endif
        exp_q.push_back(x);
        m_cur_addr  = a;
        m_cur_valid = 1'b1;
        got = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_addr  = a;
            req_ena   = e;
            if (req_ready) begin
                got = 1;
                if (b2b) chk("b2b_accept_cycle", cyc, last_done_cyc + 1);
                break;
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit got;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_ena = 1'b0;
        m_cur_addr = '0;
        m_cur_valid = 1'b0;

        reset_and_check();

        // Directed: addr 3, addr 0, then addr 5 held during the busy sequence.
        send(10'd3, 1'b1, 0);
        wait_idle();
        send(10'd0, 1'b1, 0);
        send(10'd5, 1'b0, 1);
        wait_idle();

        // Incremental-selection scenario (full sequences when disabled).
        send(10'd3, 1'b1, 0);
        wait_idle();
        send(10'd7, 1'b1, 0);
        wait_idle();
        send(10'd2, 1'b0, 0);
        wait_idle();
        send(10'd2, 1'b1, 0);
        wait_idle();

        // Randomised requests, mixing back-to-back and gapped issue.
        for (int i = 0; i < 12; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap == 0 && i != 0) begin
                send(ADDR_W'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1);
            end else begin
                wait_idle();
                repeat (gap) @(negedge clk);
                send(ADDR_W'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 0);
            end
        end
        wait_idle();

        // Boundary: maximum address.
        send(10'd1023, 1'b1, 0);
        wait_idle();

        // Reset during the second increment pulse of a full sequence.
        send(10'd0, 1'b0, 0);
        wait_idle();
        send(10'd5, 1'b1, 0);
        @(negedge clk);
        req_valid = 1'b0;
        got = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (mon_incs >= 2) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("second_inc_timeout", 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sel_inc", ctrl_sel_inc, 0);
        chk("midrst_ena", ctrl_ena, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cur_valid", cur_valid, 0);
        chk("midrst_sel_rst_n", ctrl_sel_rst_n, 0);
        exp_q.delete();
        m_cur_valid = 1'b0;
        reset_and_check();

        send(10'd2, 1'b1, 0);
        wait_idle();

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
